// File: rtl/sn_onewire_reader_if.sv
// Host control/result bundle plus the open-drain SN line pins of the serial-number reader.
interface sn_onewire_reader_if;
    logic        start;
    logic        ow_in;
    logic        ow_out;
    logic        busy;
    logic        done;
    logic [63:0] sn;
    logic        sn_valid;
    logic        no_presence;
    logic        crc_err;

    modport master (output start, ow_in,
                    input  ow_out, busy, done, sn, sn_valid, no_presence, crc_err);
    modport slave  (input  start, ow_in,
                    output ow_out, busy, done, sn, sn_valid, no_presence, crc_err);
endinterface

// File: rtl/sn_onewire_reader.sv
// Autonomous 1-Wire master: reset/presence, Read ROM (0x33), 64 read slots, CRC-8 and family check.
module sn_onewire_reader #(
    parameter int         T_RSTL     = 19200,
    parameter int         T_PDS      = 2800,
    parameter int         T_RSTH     = 19200,
    parameter int         T_LOW0     = 2400,
    parameter int         T_LOW1     = 240,
    parameter int         T_RDS      = 600,
    parameter int         T_SLOT     = 2800,
    parameter int         T_REC      = 80,
    parameter logic [7:0] FAMILY     = 8'h01,
    parameter bit         AUTO_START = 1'b1
) (
    input logic                clk,
    input logic                hard_rst,
    sn_onewire_reader_if.slave bus
);
    localparam logic [14:0] RSTL_END = 15'(T_RSTL - 1);
    localparam logic [14:0] RSTH_END = 15'(T_RSTH - 1);
    localparam logic [14:0] PDS_AT   = 15'(T_PDS);
    localparam logic [14:0] LOW0     = 15'(T_LOW0);
    localparam logic [14:0] LOW1     = 15'(T_LOW1);
    localparam logic [14:0] SLOT     = 15'(T_SLOT);
    localparam logic [14:0] REC_END  = 15'(T_REC - 1);
    localparam logic [14:0] RD_AT    = 15'(T_RDS - T_LOW1);
    localparam logic [7:0]  READ_ROM = 8'h33;

    typedef enum logic [2:0] {IDLE, RST_LOW, PRES, SLOT_LOW, SLOT_HIGH, REC, CHECK} state_t;

    state_t      state, state_nx;
    logic [14:0] cnt;
    logic [1:0]  sync;
    logic        ow_s, auto_pend, go, presence, phase_rd, cmd_bit, mismatch;
    logic [5:0]  idx;
    logic [14:0] low_len;
    logic [63:0] shreg, sn_q;
    logic [7:0]  crc;
    logic        ow_q, busy_q, done_q, valid_q, np_q, crc_err_q;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return {1'b0, c[7:1]} ^ ({8{fb}} & 8'h8C);
    endfunction

    // done_q blocks a start that coincides with the done pulse
    assign ow_s     = sync[1];
    assign go       = (bus.start || auto_pend) && !done_q;
    assign cmd_bit  = READ_ROM[idx[2:0]];
    assign low_len  = (phase_rd || cmd_bit) ? LOW1 : LOW0;
    assign mismatch = crc != shreg[63:56];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (go) state_nx = RST_LOW;
            RST_LOW:   if (cnt == RSTL_END) state_nx = PRES;
            PRES:      if (cnt == RSTH_END) state_nx = presence ? SLOT_LOW : IDLE;
            SLOT_LOW:  if (cnt == low_len - 15'd1) state_nx = SLOT_HIGH;
            SLOT_HIGH: if (cnt == SLOT - low_len - 15'd1) state_nx = REC;
            REC:       if (cnt == REC_END) state_nx = (phase_rd && idx == 6'd63) ? CHECK : SLOT_LOW;
            CHECK:     state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 15'd0 : cnt + 15'd1;
        end
    end

    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            sync      <= 2'b11;
            auto_pend <= AUTO_START;
            presence  <= 1'b0;
            phase_rd  <= 1'b0;
            idx       <= '0;
            shreg     <= '0;
            crc       <= '0;
            ow_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            np_q      <= 1'b0;
            crc_err_q <= 1'b0;
            sn_q      <= '0;
        end else begin
            sync      <= {sync[0], bus.ow_in};
            auto_pend <= 1'b0;
            done_q    <= 1'b0;
            ow_q      <= !(state_nx == RST_LOW || state_nx == SLOT_LOW);
            unique case (state)
                IDLE: if (go) begin
                    busy_q    <= 1'b1;
                    valid_q   <= 1'b0;
                    np_q      <= 1'b0;
                    crc_err_q <= 1'b0;
                end
                PRES: begin
                    if (cnt == PDS_AT) presence <= !ow_s;
                    if (state_nx == IDLE) begin
                        np_q   <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    if (state_nx == SLOT_LOW) begin
                        phase_rd <= 1'b0;
                        idx      <= '0;
                        crc      <= '0;
                    end
                end
                SLOT_HIGH: if (phase_rd && cnt == RD_AT) begin
                    shreg[idx] <= ow_s;
                    // CRC covers the first 56 bits; the last byte is the transmitted CRC
                    if (idx < 6'd56) crc <= crc_step(crc, ow_s);
                end
                REC: if (state_nx != REC) begin
                    if (!phase_rd && idx == 6'd7) begin
                        phase_rd <= 1'b1;
                        idx      <= '0;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                CHECK: begin
                    sn_q      <= shreg;
                    crc_err_q <= mismatch;
                    valid_q   <= !mismatch && shreg[7:0] == FAMILY;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ow_out      = ow_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.sn          = sn_q;
    assign bus.sn_valid    = valid_q;
    assign bus.no_presence = np_q;
    assign bus.crc_err     = crc_err_q;
endmodule

// File: tb/tb_sn_onewire_reader.sv
// Directed bench for sn_onewire_reader: behavioural DS2401 model, scaled timing, scoreboard of results.
module tb_sn_onewire_reader;
    localparam int RSTL = 48, PDS = 10, RSTH = 48, L0 = 12, L1 = 2, RDS = 8, SLOT = 16, REC = 3;
    localparam int N_OK = RSTL + RSTH + 72 * (SLOT + REC) + 2;
    localparam int N_NP = RSTL + RSTH + 1;

    typedef struct {
        logic [63:0] sn;
        logic        sn_valid;
        logic        no_presence;
        logic        crc_err;
        int          lat;
        int          falls;
    } exp_t;

    logic clk = 1'b0;
    logic hard_rst = 1'b0;
    always #5 clk = ~clk;

    sn_onewire_reader_if bus();

    sn_onewire_reader #(
        .T_RSTL(RSTL), .T_PDS(PDS), .T_RSTH(RSTH), .T_LOW0(L0), .T_LOW1(L1),
        .T_RDS(RDS), .T_SLOT(SLOT), .T_REC(REC), .FAMILY(8'h01), .AUTO_START(1'b1)
    ) dut (
        .clk(clk),
        .hard_rst(hard_rst),
        .bus(bus)
    );

    logic        dev_rel = 1'b1;
    int          mode = 0;        // 0 device present, 1 absent, 2 line stuck low after reset
    logic [63:0] rom;
    logic [7:0]  cmd_rx;
    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    assign bus.ow_in = bus.ow_out & dev_rel;

    function automatic logic [7:0] crc8(input logic [55:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 7; i++) begin
            c ^= d[i*8 +: 8];
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [63:0] mkrom(input logic [47:0] ser, input logic [7:0] fam);
        return {crc8({ser, fam}), ser, fam};
    endfunction

    function automatic exp_t mk(input logic [63:0] s, input logic v, input logic np,
                                input logic ce, input int lat, input int falls);
        exp_t e;
        e.sn = s; e.sn_valid = v; e.no_presence = np; e.crc_err = ce;
        e.lat = lat; e.falls = falls;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Device model: classifies low pulses by width, answers presence and read slots
    initial begin : device
        int   bitn, lw;
        logic rd;
        bitn = 0;
        forever begin
            @(negedge bus.ow_out);
            rd = (mode == 0) && bitn >= 8 && bitn < 72;
            if (rd) dev_rel = rom[bitn-8];
            lw = 0;
            while (bus.ow_out !== 1'b1) begin
                @(negedge clk);
                lw++;
            end
            if (lw > 30) begin
                bitn    = 0;
                cmd_rx  = 8'h00;
                dev_rel = 1'b1;
                if (mode != 1) begin
                    repeat (3) @(negedge clk);
                    dev_rel = 1'b0;
                    if (mode != 2) begin
                        repeat (14) @(negedge clk);
                        dev_rel = 1'b1;
                    end
                end
            end else begin
                if (bitn < 8) cmd_rx[bitn] = (lw < 7);
                else if (rd) begin
                    repeat (10) @(negedge clk);
                    dev_rel = 1'b1;
                end
                bitn++;
            end
        end
    end

    // Line monitor: low widths and fall times in whole clk cycles
    int   widths[$];
    int   falls_t[$];
    int   ncyc = 0;
    logic prev_ow = 1'b1;
    always @(negedge clk) begin
        ncyc++;
        if (prev_ow && !bus.ow_out) falls_t.push_back(ncyc);
        if (!prev_ow && bus.ow_out && falls_t.size() > 0) widths.push_back(ncyc - falls_t[$]);
        prev_ow = bus.ow_out;
    end

    task automatic run_seq(input exp_t e, input bit use_start, input int poke);
        int   cyc;
        bit   seen;
        exp_t x;
        sb.push_back(e);
        widths.delete();
        falls_t.delete();
        if (use_start) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < e.lat + 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("busy_after_start", bus.busy, 1'b1);
                check("ow_low_after_start", bus.ow_out, 1'b0);
            end
            if (poke != 0 && cyc == poke) bus.start = 1'b1;
            if (poke != 0 && cyc == poke + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) seen = 1;
        end
        x = sb.pop_front();
        check("done_seen", seen, 1'b1);
        check("latency", cyc, x.lat);
        check("busy_with_done", bus.busy, 1'b0);
        check("sn", bus.sn, x.sn);
        check("sn_valid", bus.sn_valid, x.sn_valid);
        check("no_presence", bus.no_presence, x.no_presence);
        check("crc_err", bus.crc_err, x.crc_err);
        check("ow_falls", falls_t.size(), x.falls);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_at_done_ignored", {bus.busy, bus.ow_out}, 2'b01);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] rom_a, rom_b, rom_c, rom_f;
        int          exp_w[8];
        bit          got;
        exp_w = '{L1, L1, L0, L0, L1, L1, L0, L0};
        rom_a = mkrom(48'h0000_1234_5678, 8'h01);
        rom_b = mkrom(48'hABCD_EF01_2345, 8'h01);
        rom_c = rom_a ^ (64'h1 << 61);
        rom_f = mkrom(48'h0000_00C0_FFEE, 8'h28);
        bus.start = 1'b0;
        rom = rom_a;

        repeat (3) @(negedge clk);
        check("rst_ow_out", bus.ow_out, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_sn", bus.sn, 64'h0);
        check("rst_flags", {bus.sn_valid, bus.no_presence, bus.crc_err}, 3'b000);

        // auto-start after reset release, normal device
        hard_rst = 1'b1;
        run_seq(mk(rom_a, 1'b1, 1'b0, 1'b0, N_OK, 73), 1'b0, 0);
        check("cmd_byte", cmd_rx, 8'h33);
        check("rst_low_width", widths[0], RSTL);
        check("rst_to_slot", falls_t[1] - falls_t[0], RSTL + RSTH);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("cmd%0d_low", i), widths[i+1], exp_w[i]);
            check($sformatf("cmd%0d_span", i), falls_t[i+2] - falls_t[i+1], SLOT + REC);
        end

        // start pulse mid read slot must be ignored
        rom = rom_b;
        run_seq(mk(rom_b, 1'b1, 1'b0, 1'b0, N_OK, 73), 1'b1, RSTL + RSTH + 28 * (SLOT + REC) + 5);

        // no device: sn keeps previous value
        mode = 1;
        run_seq(mk(rom_b, 1'b0, 1'b1, 1'b0, N_NP, 1), 1'b1, 0);

        // corrupted CRC byte
        mode = 0;
        rom  = rom_c;
        run_seq(mk(rom_c, 1'b0, 1'b0, 1'b1, N_OK, 73), 1'b1, 0);

        // line stuck low after reset pulse
        mode = 2;
        run_seq(mk(64'h0, 1'b0, 1'b0, 1'b0, N_OK, 73), 1'b1, 0);

        // good CRC, wrong family
        mode = 0;
        rom  = rom_f;
        run_seq(mk(rom_f, 1'b0, 1'b0, 1'b0, N_OK, 73), 1'b1, 0);

        // hard reset in a command SLOT_LOW, then auto restart
        rom = rom_a;
        falls_t.delete();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (falls_t.size() >= 5 && bus.ow_out === 1'b0) got = 1;
        end
        check("reach_slot_low", got, 1'b1);
        #2 hard_rst = 1'b0;
        #1;
        check("async_release_ow", bus.ow_out, 1'b1);
        check("async_busy", bus.busy, 1'b0);
        repeat (20) @(negedge clk);
        hard_rst = 1'b1;
        run_seq(mk(rom_a, 1'b1, 1'b0, 1'b0, N_OK, 73), 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
